// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the integer register file and the stages around it.
package regfile_mp_pkg;

    localparam int unsigned RF_DW   = 64;
    localparam int unsigned RF_NREG = 32;

    localparam logic [RF_DW-1:0] ZERO_WORD = '0;

    // Where a read port's data came from this cycle.
    typedef enum logic {
        RD_STORED  = 1'b0,
        RD_FORWARD = 1'b1
    } rd_src_e;

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Busy scoreboard: one pending bit per architectural register.
module rf_scoreboard #(
    parameter int NREG     = 32,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NWR-1:0]    w_ena,
    input  logic [NWR*AW-1:0] w_addr,
    input  logic              iss_ena,
    input  logic [AW-1:0]     iss_addr,
    output logic [NREG-1:0]   busy
);

    logic [NREG-1:0] busy_nxt;

    // Writebacks clear, issue sets afterwards so a new producer wins a same-cycle race.
    always_comb begin
        busy_nxt = busy;
        for (int unsigned j = 0; j < NWR; j++) begin
            if (w_ena[j]) begin
                busy_nxt[w_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (iss_ena) begin
            busy_nxt[iss_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_nxt[0] = 1'b0;
        end
    end

    // Busy vector register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass and busy scoreboard.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DW       = RF_DW,
    parameter int NREG     = RF_NREG,
    parameter int NRD      = 4,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NWR-1:0]     w_ena,
    input  logic [NWR*AW-1:0]  w_addr,
    input  logic [NWR*DW-1:0]  w_data,
    input  logic [NRD-1:0]     r_ena,
    input  logic [NRD*AW-1:0]  r_addr,
    output logic [NRD*DW-1:0]  r_data,
    output logic [NRD-1:0]     r_busy,
    input  logic               iss_ena,
    input  logic [AW-1:0]      iss_addr,
    output logic [NREG-1:0]    busy_o,
    output logic [NREG*DW-1:0] regs_o
);

    logic [DW-1:0] regs [NREG];

    // Storage update; ports are visited in ascending order so the highest index wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < NWR; j++) begin
                if (w_ena[j] && !(ZERO_REG != 0 && w_addr[j*AW +: AW] == '0)) begin
                    regs[w_addr[j*AW +: AW]] <= w_data[j*DW +: DW];
                end
            end
        end
    end

    rf_scoreboard #(
        .NREG     (NREG),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .w_ena    (w_ena),
        .w_addr   (w_addr),
        .iss_ena  (iss_ena),
        .iss_addr (iss_addr),
        .busy     (busy_o)
    );

    for (genvar i = 0; i < NREG; i++) begin : g_snap
        assign regs_o[i*DW +: DW] = regs[i];
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0] ra;
        logic [DW-1:0] rd_val;
        rd_src_e       src;

        assign ra = r_addr[p*AW +: AW];

        // Read mux: stored value, overridden by the highest matching live write when bypassing.
        always_comb begin
            rd_val = regs[ra];
            src    = RD_STORED;
            if (BYPASS != 0) begin
                for (int unsigned j = 0; j < NWR; j++) begin
                    if (w_ena[j] && w_addr[j*AW +: AW] == ra &&
                        !(ZERO_REG != 0 && ra == '0)) begin
                        rd_val = w_data[j*DW +: DW];
                        src    = RD_FORWARD;
                    end
                end
            end
            if (!r_ena[p] || (ZERO_REG != 0 && ra == '0)) begin
                rd_val = DW'(ZERO_WORD);
            end
            // Forwarded data is final, so the operand is no longer pending.
            r_busy[p] = r_ena[p] && busy_o[ra] && (src == RD_STORED);
        end

        assign r_data[p*DW +: DW] = rd_val;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: two configurations driven in lockstep against a reference model.
module tb_regfile_mp;

    localparam int DW = 64, NREG = 32, AW = 5, NRD = 4, NWR = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NWR-1:0]     w_ena = '0;
    logic [NWR*AW-1:0]  w_addr = '0;
    logic [NWR*DW-1:0]  w_data = '0;
    logic [NRD-1:0]     r_ena = '0;
    logic [NRD*AW-1:0]  r_addr = '0;
    logic               iss_ena = 1'b0;
    logic [AW-1:0]      iss_addr = '0;

    logic [NRD*DW-1:0]  r_data0, r_data1;
    logic [NRD-1:0]     r_busy0, r_busy1;
    logic [NREG-1:0]    busy0, busy1;
    logic [NREG*DW-1:0] regs0, regs1;

    always #5 clk = ~clk;

    // dut 0: BYPASS=1, ZERO_REG=1
    regfile_mp dut_main (
        .clk(clk), .rst_n(rst_n), .w_ena(w_ena), .w_addr(w_addr), .w_data(w_data),
        .r_ena(r_ena), .r_addr(r_addr), .r_data(r_data0), .r_busy(r_busy0),
        .iss_ena(iss_ena), .iss_addr(iss_addr), .busy_o(busy0), .regs_o(regs0)
    );

    // dut 1: BYPASS=0, ZERO_REG=0
    regfile_mp #(.BYPASS(0), .ZERO_REG(0)) dut_alt (
        .clk(clk), .rst_n(rst_n), .w_ena(w_ena), .w_addr(w_addr), .w_data(w_data),
        .r_ena(r_ena), .r_addr(r_addr), .r_data(r_data1), .r_busy(r_busy1),
        .iss_ena(iss_ena), .iss_addr(iss_addr), .busy_o(busy1), .regs_o(regs1)
    );

    typedef struct {
        int          kind;   // 0 r_data, 1 r_busy, 2 busy_o, 3 regs_o
        int          dut;
        int          idx;
        logic [63:0] exp;
    } item_t;

    item_t q[$];
    int    total = 0;
    int    bad = 0;

    // staged stimulus for the next cycle
    bit          s_rst;
    logic [1:0]  s_wen;
    logic [4:0]  s_wa [NWR];
    logic [63:0] s_wd [NWR];
    logic [3:0]  s_ren;
    logic [4:0]  s_ra [NRD];
    bit          s_iss;
    logic [4:0]  s_ia;

    // reference state per configuration
    logic [63:0] mr [2][NREG];
    bit          mb [2][NREG];

    function automatic string kname(int k);
        case (k)
            0: return "r_data";
            1: return "r_busy";
            2: return "busy_o";
            default: return "regs_o";
        endcase
    endfunction

    task automatic idle();
        s_rst = 1'b1;
        s_wen = '0;
        s_ren = '0;
        s_iss = 1'b0;
        s_ia  = '0;
        for (int j = 0; j < NWR; j++) begin s_wa[j] = '0; s_wd[j] = '0; end
        for (int p = 0; p < NRD; p++) s_ra[p] = '0;
    endtask

    task automatic wr(input int port, input int addr, input logic [63:0] data);
        s_wen[port] = 1'b1;
        s_wa[port]  = 5'(addr);
        s_wd[port]  = data;
    endtask

    task automatic rd(input int port, input int addr);
        s_ren[port] = 1'b1;
        s_ra[port]  = 5'(addr);
    endtask

    task automatic iss(input int addr);
        s_iss = 1'b1;
        s_ia  = 5'(addr);
    endtask

    // Reference: register file semantics written directly from the architectural rules.
    task automatic run_model();
        item_t       it;
        logic [63:0] v;
        bit          b;
        bit          zr, byp;
        logic [63:0] bv;
        for (int d = 0; d < 2; d++) begin
            zr  = (d == 0);
            byp = (d == 0);
            if (!s_rst) begin
                for (int r = 0; r < NREG; r++) begin mr[d][r] = '0; mb[d][r] = 1'b0; end
            end
            bv = '0;
            for (int r = 0; r < NREG; r++) bv[r] = mb[d][r];
            it = '{kind: 2, dut: d, idx: 0, exp: bv};
            q.push_back(it);
            for (int r = 0; r < NREG; r++) begin
                it = '{kind: 3, dut: d, idx: r, exp: mr[d][r]};
                q.push_back(it);
            end
            for (int p = 0; p < NRD; p++) begin
                v = '0;
                b = 1'b0;
                if (s_ren[p]) begin
                    if (zr && s_ra[p] == 0) begin
                        v = '0;
                        b = 1'b0;
                    end else begin
                        v = mr[d][s_ra[p]];
                        b = mb[d][s_ra[p]];
                        if (byp) begin
                            for (int j = NWR - 1; j >= 0; j--) begin
                                if (s_wen[j] && s_wa[j] == s_ra[p]) begin
                                    v = s_wd[j];
                                    b = 1'b0;
                                    break;
                                end
                            end
                        end
                    end
                end
                it = '{kind: 0, dut: d, idx: p, exp: v};
                q.push_back(it);
                it = '{kind: 1, dut: d, idx: p, exp: {63'b0, b}};
                q.push_back(it);
            end
            if (s_rst) begin
                for (int j = 0; j < NWR; j++) begin
                    if (s_wen[j] && !(zr && s_wa[j] == 0)) mr[d][s_wa[j]] = s_wd[j];
                    if (s_wen[j]) mb[d][s_wa[j]] = 1'b0;
                end
                if (s_iss) mb[d][s_ia] = 1'b1;
                if (zr) mb[d][0] = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        rst_n    = s_rst;
        w_ena    = s_wen;
        r_ena    = s_ren;
        iss_ena  = s_iss;
        iss_addr = s_ia;
        for (int j = 0; j < NWR; j++) begin
            w_addr[j*AW +: AW] = s_wa[j];
            w_data[j*DW +: DW] = s_wd[j];
        end
        for (int p = 0; p < NRD; p++) r_addr[p*AW +: AW] = s_ra[p];
        run_model();
        idle();
    endtask

    // Monitor: outputs are settled by the falling edge; drain what the stimulus queued.
    initial begin
        item_t       it;
        logic [63:0] act;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                it = q.pop_front();
                case (it.kind)
                    0: act = it.dut != 0 ? r_data1[it.idx*DW +: DW] : r_data0[it.idx*DW +: DW];
                    1: act = {63'b0, it.dut != 0 ? r_busy1[it.idx] : r_busy0[it.idx]};
                    2: act = {32'b0, it.dut != 0 ? busy1 : busy0};
                    default: act = it.dut != 0 ? regs1[it.idx*DW +: DW] : regs0[it.idx*DW +: DW];
                endcase
                total++;
                if (act !== it.exp) begin
                    bad++;
                    $display("FAIL %s dut=%0d idx=%0d t=%0t got=%h want=%h",
                             kname(it.kind), it.dut, it.idx, $time, act, it.exp);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < NREG; r++) begin mr[d][r] = '0; mb[d][r] = 1'b0; end
        idle();

        // reset state
        s_rst = 1'b0; cycle();
        s_rst = 1'b0; cycle();

        // write x5 then async reset mid-run
        wr(0, 5, 64'hDEAD); rd(0, 5); iss(5); cycle();
        rd(0, 5); cycle();
        s_rst = 1'b0; rd(0, 5); cycle();
        cycle();

        // dual-port collision on x7
        wr(0, 7, 64'h11); wr(1, 7, 64'h22);
        for (int p = 0; p < NRD; p++) rd(p, 7);
        cycle();
        rd(0, 7); cycle();

        // zero register
        wr(0, 0, 64'hFFFF); iss(0); rd(0, 0); cycle();
        rd(0, 0); rd(1, 0); cycle();

        // bypass on/off with a pending destination
        iss(3); cycle();
        wr(1, 3, 64'h1234); rd(0, 3); cycle();
        rd(0, 3); cycle();

        // scoreboard race on x9
        iss(9); cycle();
        wr(0, 9, 64'h99); iss(9); rd(2, 9); cycle();
        rd(2, 9); cycle();
        wr(1, 9, 64'h98); cycle();
        rd(2, 9); cycle();

        // all read ports
        wr(0, 1, 64'd1); wr(1, 2, 64'd2); cycle();
        wr(0, 3, 64'd3); wr(1, 4, 64'd4); cycle();
        for (int p = 0; p < NRD; p++) rd(p, p + 1);
        cycle();
        rd(0, 1); rd(2, 3); s_ra[1] = 5'd2; s_ra[3] = 5'd4; cycle();

        // randomized traffic, addresses biased low to provoke collisions
        for (int n = 0; n < 400; n++) begin
            s_rst = ($urandom_range(0, 63) != 0);
            for (int j = 0; j < NWR; j++)
                if ($urandom_range(0, 1) != 0)
                    wr(j, $urandom_range(0, 1) != 0 ? $urandom_range(0, 9) : $urandom_range(0, 31),
                       {$urandom, $urandom});
            for (int p = 0; p < NRD; p++)
                if ($urandom_range(0, 3) != 0)
                    rd(p, $urandom_range(0, 1) != 0 ? $urandom_range(0, 9) : $urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0) iss($urandom_range(0, 1) != 0 ? $urandom_range(0, 9) : $urandom_range(0, 31));
            cycle();
        end

        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file with an integrated busy scoreboard.
- Successor to the single-write, dual-read register file.
- Sits between decode/issue (read operands, mark destinations pending) and writeback (commit results, clear pending).
- Adds configurable read/write port counts, write-to-read bypass, and per-register busy tracking for issue-stage hazard checks.

Parameters:
- DW, 64, register data width in bits
- NREG, 32, number of architectural registers (power of two, >=2)
- AW, $clog2(NREG), register address width (derived, not overridden)
- NRD, 4, number of read ports
- NWR, 2, number of write ports
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads return stored value only
- ZERO_REG, 1, 1 = register 0 hardwired to zero, never busy; 0 = register 0 ordinary

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- w_ena  in  NWR  per-port write enable
- w_addr  in  NWR*AW  write addresses, port i at [i*AW +: AW]
- w_data  in  NWR*DW  write data, port i at [i*DW +: DW]
- r_ena  in  NRD  per-port read enable
- r_addr  in  NRD*AW  read addresses
- r_data  out  NRD*DW  read data, combinational
- r_busy  out  NRD  busy bit of addressed register, combinational; 0 when r_ena=0
- iss_ena  in  1  mark destination register busy
- iss_addr  in  AW  destination being issued
- busy_o  out  NREG  scoreboard vector, registered
- regs_o  out  NREG*DW  flattened register snapshot for difftest, registered

Behaviour:
- Reset (rst_n=0, async): all registers = 0 and busy_o = 0 immediately; regs_o = 0. Reset deasserting mid-operation resumes from the all-zero state; no pending writes are retained.
- Write: on a posedge, every port with w_ena=1 stores w_data into regs[w_addr].
  - ZERO_REG=1: writes to address 0 are dropped.
  - Two ports writing the same address in one cycle: the higher port index wins.
- Read, combinational:
  - r_ena=0 -> r_data = 0.
  - Otherwise r_data = regs[r_addr].
  - ZERO_REG=1 and r_addr=0 -> r_data = 0.
  - BYPASS=1 and some w_ena port matches r_addr (and the address is not a dropped zero-register write): r_data = that port's w_data, highest matching index wins.
  - BYPASS=0: stored value only; new data is visible the cycle after the write.
- Scoreboard, per register, updated on posedge:
  - Set when iss_ena=1 and iss_addr matches.
  - Cleared when any w_ena port writes it.
  - Same-cycle set and clear on one register: set wins, since the new producer supersedes the committing one.
  - ZERO_REG=1: busy[0] is held at 0.
  - iss_ena to an already-busy register keeps it busy; there is no counting, and one writeback clears it.
- r_busy:
  - Equals busy_o[r_addr] for the current cycle, with no forwarding of same-cycle clears.
  - BYPASS=1: a read whose address matches an active write port reports r_busy = 0, because its data is forwarded.
- Latency: read 0 cycles; write visible in storage 1 cycle; busy set/clear visible on busy_o 1 cycle after the edge.
- regs_o reflects storage, not bypass.
- There is no illegal state. Out-of-range addresses cannot occur because NREG is a power of two.

Decomposition:
- Shared package: DW/NREG defaults and the ZERO_WORD constant, reused by existing stages.
- Natural sub-module: rf_scoreboard (busy vector, set/clear priority, zero-register masking).
- Data array, write-priority, and bypass muxing stay in regfile_mp, using generate loops over NRD/NWR.

Test Plan:
- Reset mid-run: write x5=0xDEAD, pulse rst_n low asynchronously between edges -> regs_o all 0, busy_o=0 immediately, before the next edge.
- Dual write collision: w_ena=2'b11, both ports address 7, data 0x11 (port0) / 0x22 (port1) -> regs[7]=0x22 next cycle; BYPASS=1 read of 7 in the same cycle returns 0x22.
- Zero register: write 0xFFFF to x0 and iss_ena on x0 -> r_data(x0)=0, busy_o[0]=0. Repeat with ZERO_REG=0 -> reads 0xFFFF, busy_o[0]=1.
- Bypass on/off: write x3=0x1234 with a concurrent read of x3 -> BYPASS=1 gives 0x1234 and r_busy=0; BYPASS=0 gives the old value 0, then 0x1234 the next cycle.
- Scoreboard race:
  - iss x9 -> busy_o[9]=1.
  - Write x9 together with iss x9 in the same cycle -> busy_o[9] stays 1.
  - Write x9 alone next -> busy_o[9]=0.
- All ports: NRD=4 reads of x1..x4 after loading 1..4 -> r_data={4,3,2,1}. With r_ena=4'b0101 -> ports 1 and 3 read 0.
